obstacle_edge_streamer: RTL and testbench
=========================================

Name: obstacle_edge_streamer

Overview:
Takes a snapshot of the on-screen obstacle set: per-obstacle vertex lists, side counts and the obstacle count. It then streams every polygon edge, one edge per handshake, to a downstream consumer such as a collision checker or a line rasterizer. It is the read-out end of the obstacle collection path: the collector builds the arrays and this block serializes them.

Parameters:
WORLD_BITS, 32, width of one signed world coordinate
MAX_NUM_VERTICES, 8, vertex slots per obstacle
MAX_OBSTACLES_ON_SCREEN, 16, obstacle slots

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
start_in  input  1  single-cycle request to snapshot inputs and begin streaming
obstacles_x_in  input  signed WORLD_BITS x [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES]  vertex x coordinates
obstacles_y_in  input  signed WORLD_BITS x [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES]  vertex y coordinates
obstacles_num_sides_in  input  $clog2(MAX_NUM_VERTICES+1) x [MAX_OBSTACLES_ON_SCREEN]  side count per obstacle
num_obstacles_in  input  $clog2(MAX_OBSTACLES_ON_SCREEN+1)  valid obstacle count
edge_ready_in  input  1  consumer accepts the current edge
edge_valid_out  output  1  edge data valid
edge_x0_out, edge_y0_out  output  signed WORLD_BITS  edge start vertex
edge_x1_out, edge_y1_out  output  signed WORLD_BITS  edge end vertex
edge_obstacle_idx_out  output  $clog2(MAX_OBSTACLES_ON_SCREEN)  source obstacle
edge_last_of_obstacle_out  output  1  final edge of this obstacle
busy_out  output  1  streaming in progress
done_out  output  1  one-cycle pulse when the stream completes

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE. All outputs are 0. Snapshot registers are cleared. Reset mid-stream aborts immediately with no done_out.
- States: IDLE, SCAN, EMIT, FINISH.
- IDLE:
  - start_in high at clock edge T: register all inputs into the snapshot, obstacle index = 0, busy_out = 1 from T+1, go to SCAN.
  - start_in is ignored in every state other than IDLE.
- Clamping at snapshot: the obstacle count is clamped to MAX_OBSTACLES_ON_SCREEN, and each side count is clamped to MAX_NUM_VERTICES.
- SCAN (one cycle per examined obstacle):
  - If index >= count, go to FINISH.
  - Else if sides[index] < 2, index++ and stay in SCAN.
  - Else vertex = 0, load edge registers, go to EMIT.
- EMIT:
  - edge_valid_out = 1.
  - Edge k runs from v[k] to v[(k+1) mod n]; the last edge wraps to v[0].
  - edge_last_of_obstacle_out = 1 when k = n-1.
  - Data and valid hold stable while edge_ready_in is low.
  - On valid & ready with k < n-1: the next edge is presented the following cycle, giving 1 edge/cycle throughput.
  - On valid & ready with k = n-1: index++, go to SCAN. This costs one bubble cycle with valid low.
  - n = 2 emits two edges, v0→v1 and v1→v0.
- FINISH: done_out = 1 for exactly one cycle, busy_out = 0, edge outputs return to 0, go to IDLE. A start_in in that same cycle is ignored.
- Empty input (count 0): start at T, SCAN at T+1, FINISH at T+2 (done_out high), IDLE at T+3. Valid never asserts.
- Indexing: all indices are unsigned; the vertex index wrap uses the clamped n.
- Snapshot isolation: input changes during streaming do not affect the stream.

Test Plan:
- 1 obstacle, 3 sides, (0,0),(10,0),(0,10), ready held high:
  - start → edges (0,0)-(10,0), (10,0)-(0,10), (0,10)-(0,0) on consecutive cycles.
  - last flag set on the third edge; done_out pulses 2 cycles after the third acceptance.
- Count = 3 with sides {4, 1, 2}:
  - 4 edges of obstacle 0, obstacle 1 skipped, 2 edges of obstacle 2 (v0→v1, v1→v0).
  - edge_obstacle_idx_out reads 0,0,0,0,2,2.
- Backpressure: ready toggles 1,0,0,1 during a 4-sided obstacle → data and valid hold unchanged across the stalled cycles; no edge is dropped or duplicated.
- Count = 0 → no valid; done_out high exactly 2 cycles after start; start_in pulsed while busy is ignored and produces no second done_out.
- Clamping: count = 20 and sides = 15 with MAX values 16 and 8 → 16 obstacles × 8 edges = 128 handshakes; the wrap edge is v7→v0.
- Assert reset mid-EMIT → all outputs 0 asynchronously; after release, start_in restarts the stream from obstacle 0 with a fresh snapshot.

Source files
------------

// File: rtl/obstacle_edge_streamer.sv
// obstacle_edge_streamer: snapshots the on-screen obstacle set and streams
// every polygon edge (v[k] -> v[(k+1) mod n]) one per valid/ready handshake.
module obstacle_edge_streamer #(
  parameter int WORLD_BITS              = 32,
  parameter int MAX_NUM_VERTICES        = 8,
  parameter int MAX_OBSTACLES_ON_SCREEN = 16
) (
  input  logic                                           clk_in,
  input  logic                                           rst_in,
  input  logic                                           start_in,
  input  logic signed [WORLD_BITS-1:0]                   obstacles_x_in [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES],
  input  logic signed [WORLD_BITS-1:0]                   obstacles_y_in [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES],
  input  logic [$clog2(MAX_NUM_VERTICES+1)-1:0]          obstacles_num_sides_in [MAX_OBSTACLES_ON_SCREEN],
  input  logic [$clog2(MAX_OBSTACLES_ON_SCREEN+1)-1:0]   num_obstacles_in,
  input  logic                                           edge_ready_in,
  output logic                                           edge_valid_out,
  output logic signed [WORLD_BITS-1:0]                   edge_x0_out,
  output logic signed [WORLD_BITS-1:0]                   edge_y0_out,
  output logic signed [WORLD_BITS-1:0]                   edge_x1_out,
  output logic signed [WORLD_BITS-1:0]                   edge_y1_out,
  output logic [$clog2(MAX_OBSTACLES_ON_SCREEN)-1:0]     edge_obstacle_idx_out,
  output logic                                           edge_last_of_obstacle_out,
  output logic                                           busy_out,
  output logic                                           done_out
);

  localparam int SW = $clog2(MAX_NUM_VERTICES + 1);        // side-count width
  localparam int CW = $clog2(MAX_OBSTACLES_ON_SCREEN + 1); // obstacle-count width
  localparam int IW = $clog2(MAX_OBSTACLES_ON_SCREEN);     // obstacle-index width
  localparam int VW = $clog2(MAX_NUM_VERTICES);            // vertex-slot index width

  localparam logic [SW-1:0] MAX_SIDES = SW'(MAX_NUM_VERTICES);
  localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_OBSTACLES_ON_SCREEN);
  localparam logic [SW-1:0] MIN_SIDES = SW'(2);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    FINISH
  } state_t;

  state_t state;

  // Snapshot of the obstacle set taken when a stream starts
  logic signed [WORLD_BITS-1:0] snap_x [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] snap_y [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES];
  logic [SW-1:0]                snap_sides [MAX_OBSTACLES_ON_SCREEN];
  logic [CW-1:0]                snap_count;

  // Walk position: obstacle index (can reach the count) and edge number k
  logic [CW-1:0] idx;
  logic [SW-1:0] k;

  // Derived walk values
  logic [IW-1:0] idx_lo;
  logic [SW-1:0] n_cur;
  logic [SW-1:0] k_inc;
  logic [SW-1:0] k_inc2;
  logic [SW-1:0] k_wrap;
  logic          k_is_last;
  logic          k_inc_is_last;
  logic          snap_load;

  assign snap_load = (state == IDLE) && start_in;

  // Capture the inputs on an accepted start, clamping counts to their array sizes
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      snap_count <= '0;
      for (int unsigned i = 0; i < MAX_OBSTACLES_ON_SCREEN; i++) begin
        snap_sides[i] <= '0;
        for (int unsigned j = 0; j < MAX_NUM_VERTICES; j++) begin
          snap_x[i][j] <= '0;
          snap_y[i][j] <= '0;
        end
      end
    end else if (snap_load) begin
      snap_count <= (num_obstacles_in > MAX_COUNT) ? MAX_COUNT : num_obstacles_in;
      for (int unsigned i = 0; i < MAX_OBSTACLES_ON_SCREEN; i++) begin
        snap_sides[i] <= (obstacles_num_sides_in[i] > MAX_SIDES) ? MAX_SIDES
                                                                 : obstacles_num_sides_in[i];
        for (int unsigned j = 0; j < MAX_NUM_VERTICES; j++) begin
          snap_x[i][j] <= obstacles_x_in[i][j];
          snap_y[i][j] <= obstacles_y_in[i][j];
        end
      end
    end
  end

  // Next-edge vertex indices for the current obstacle; k_wrap closes the polygon at v0
  always_comb begin
    idx_lo        = idx[IW-1:0];
    n_cur         = snap_sides[idx_lo];
    k_inc         = k + 1'b1;
    k_inc2        = k_inc + 1'b1;
    k_wrap        = (k_inc2 == n_cur) ? '0 : k_inc2;
    k_is_last     = (k == (n_cur - 1'b1));
    k_inc_is_last = (k_inc == (n_cur - 1'b1));
  end

  // Streaming FSM with registered edge, busy and done outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state                     <= IDLE;
      idx                       <= '0;
      k                         <= '0;
      edge_valid_out            <= 1'b0;
      edge_x0_out               <= '0;
      edge_y0_out               <= '0;
      edge_x1_out               <= '0;
      edge_y1_out               <= '0;
      edge_obstacle_idx_out     <= '0;
      edge_last_of_obstacle_out <= 1'b0;
      busy_out                  <= 1'b0;
      done_out                  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            idx      <= '0;
            k        <= '0;
            busy_out <= 1'b1;
            state    <= SCAN;
          end
        end

        SCAN: begin
          if (idx >= snap_count) begin
            edge_valid_out            <= 1'b0;
            edge_x0_out               <= '0;
            edge_y0_out               <= '0;
            edge_x1_out               <= '0;
            edge_y1_out               <= '0;
            edge_obstacle_idx_out     <= '0;
            edge_last_of_obstacle_out <= 1'b0;
            busy_out                  <= 1'b0;
            done_out                  <= 1'b1;
            state                     <= FINISH;
          end else if (n_cur < MIN_SIDES) begin
            idx <= idx + 1'b1;
          end else begin
            // First edge is always v0 -> v1; with n >= 2 it is never the last
            k                         <= '0;
            edge_x0_out               <= snap_x[idx_lo][0];
            edge_y0_out               <= snap_y[idx_lo][0];
            edge_x1_out               <= snap_x[idx_lo][1];
            edge_y1_out               <= snap_y[idx_lo][1];
            edge_obstacle_idx_out     <= idx_lo;
            edge_last_of_obstacle_out <= 1'b0;
            edge_valid_out            <= 1'b1;
            state                     <= EMIT;
          end
        end

        EMIT: begin
          if (edge_ready_in) begin
            if (k_is_last) begin
              edge_valid_out            <= 1'b0;
              edge_x0_out               <= '0;
              edge_y0_out               <= '0;
              edge_x1_out               <= '0;
              edge_y1_out               <= '0;
              edge_obstacle_idx_out     <= '0;
              edge_last_of_obstacle_out <= 1'b0;
              idx                       <= idx + 1'b1;
              state                     <= SCAN;
            end else begin
              k                         <= k_inc;
              edge_x0_out               <= snap_x[idx_lo][k_inc[VW-1:0]];
              edge_y0_out               <= snap_y[idx_lo][k_inc[VW-1:0]];
              edge_x1_out               <= snap_x[idx_lo][k_wrap[VW-1:0]];
              edge_y1_out               <= snap_y[idx_lo][k_wrap[VW-1:0]];
              edge_last_of_obstacle_out <= k_inc_is_last;
            end
          end
        end

        FINISH: begin
          done_out <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_edge_streamer.sv
// Testbench for obstacle_edge_streamer: a cycle-item reference model built
// from the obstacle set drives expectations for every sampled cycle.
module tb_obstacle_edge_streamer;

  localparam int WB = 32;
  localparam int MV = 8;
  localparam int MO = 16;

  localparam int K_BUB  = 0; // cycle with no edge presented, still busy
  localparam int K_EDGE = 1; // edge presented until accepted
  localparam int K_FIN  = 2; // done pulse cycle

  typedef struct {
    int                   kind;
    logic signed [WB-1:0] x0;
    logic signed [WB-1:0] y0;
    logic signed [WB-1:0] x1;
    logic signed [WB-1:0] y1;
    int                   idx;
    bit                   last;
  } item_t;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b0;
  logic                 start_in = 1'b0;
  logic                 edge_ready_in = 1'b0;
  logic signed [WB-1:0] ox [MO][MV];
  logic signed [WB-1:0] oy [MO][MV];
  logic [3:0]           os [MO];
  logic [4:0]           onum;

  logic                 edge_valid_out;
  logic signed [WB-1:0] edge_x0_out;
  logic signed [WB-1:0] edge_y0_out;
  logic signed [WB-1:0] edge_x1_out;
  logic signed [WB-1:0] edge_y1_out;
  logic [3:0]           edge_obstacle_idx_out;
  logic                 edge_last_of_obstacle_out;
  logic                 busy_out;
  logic                 done_out;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    dut_hs = 0;
  item_t q[$];

  always #5 clk_in = ~clk_in;

  obstacle_edge_streamer #(
    .WORLD_BITS(WB),
    .MAX_NUM_VERTICES(MV),
    .MAX_OBSTACLES_ON_SCREEN(MO)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .obstacles_x_in(ox),
    .obstacles_y_in(oy),
    .obstacles_num_sides_in(os),
    .num_obstacles_in(onum),
    .edge_ready_in(edge_ready_in),
    .edge_valid_out(edge_valid_out),
    .edge_x0_out(edge_x0_out),
    .edge_y0_out(edge_y0_out),
    .edge_x1_out(edge_x1_out),
    .edge_y1_out(edge_y1_out),
    .edge_obstacle_idx_out(edge_obstacle_idx_out),
    .edge_last_of_obstacle_out(edge_last_of_obstacle_out),
    .busy_out(busy_out),
    .done_out(done_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(edge_valid_out), 64'd0);
    chk({tag, "_busy"},  64'(busy_out), 64'd0);
    chk({tag, "_done"},  64'(done_out), 64'd0);
    chk({tag, "_x0"},    64'(edge_x0_out), 64'd0);
    chk({tag, "_y0"},    64'(edge_y0_out), 64'd0);
    chk({tag, "_x1"},    64'(edge_x1_out), 64'd0);
    chk({tag, "_y1"},    64'(edge_y1_out), 64'd0);
    chk({tag, "_idx"},   64'(edge_obstacle_idx_out), 64'd0);
    chk({tag, "_last"},  64'(edge_last_of_obstacle_out), 64'd0);
  endtask

  task automatic fill_random();
    onum = 5'($urandom_range(0, 20));
    for (int i = 0; i < MO; i++) begin
      os[i] = 4'($urandom_range(0, 15));
      for (int j = 0; j < MV; j++) begin
        ox[i][j] = $urandom;
        oy[i][j] = $urandom;
      end
    end
  endtask

  // Expected cycle items: per examined obstacle one scan bubble then its edges,
  // then one final scan bubble and the done cycle.
  task automatic build_model();
    int    cnt;
    int    n;
    item_t it;
    q.delete();
    cnt = (int'(onum) > MO) ? MO : int'(onum);
    for (int i = 0; i < cnt; i++) begin
      it = '{kind: K_BUB, x0: '0, y0: '0, x1: '0, y1: '0, idx: 0, last: 1'b0};
      q.push_back(it);
      n = (int'(os[i]) > MV) ? MV : int'(os[i]);
      if (n >= 2) begin
        for (int e = 0; e < n; e++) begin
          it.kind = K_EDGE;
          it.x0   = ox[i][e];
          it.y0   = oy[i][e];
          it.x1   = ox[i][(e + 1) % n];
          it.y1   = oy[i][(e + 1) % n];
          it.idx  = i;
          it.last = (e == n - 1);
          q.push_back(it);
        end
      end
    end
    it = '{kind: K_BUB, x0: '0, y0: '0, x1: '0, y1: '0, idx: 0, last: 1'b0};
    q.push_back(it);
    it.kind = K_FIN;
    q.push_back(it);
  endtask

  // mode: 0 ready high, 1 random ready, 2 ready pattern 1,0,0,1 over edge cycles
  task automatic run(input string tag, input int mode, input bit pulses, input int abort_at);
    int    m;
    int    pat;
    bit    r;
    item_t it;
    build_model();
    dut_hs   = 0;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    fill_random(); // inputs change mid-stream; the snapshot must not
    m   = 1;
    pat = 0;
    while (q.size() > 0 && m < 3000) begin
      it = q[0];
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = ((pat % 4) == 0) || ((pat % 4) == 3);
      endcase
      edge_ready_in = r;
      start_in      = pulses ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (edge_valid_out && r) dut_hs++;
      chk({tag, "_valid"}, 64'(edge_valid_out), 64'(it.kind == K_EDGE));
      chk({tag, "_busy"},  64'(busy_out), 64'(it.kind != K_FIN));
      chk({tag, "_done"},  64'(done_out), 64'(it.kind == K_FIN));
      if (it.kind == K_EDGE) begin
        chk({tag, "_x0"},   64'(edge_x0_out), 64'(it.x0));
        chk({tag, "_y0"},   64'(edge_y0_out), 64'(it.y0));
        chk({tag, "_x1"},   64'(edge_x1_out), 64'(it.x1));
        chk({tag, "_y1"},   64'(edge_y1_out), 64'(it.y1));
        chk({tag, "_idx"},  64'(edge_obstacle_idx_out), 64'(it.idx));
        chk({tag, "_last"}, 64'(edge_last_of_obstacle_out), 64'(it.last));
        pat++;
      end
      if (abort_at != 0 && m == abort_at) begin
        edge_ready_in = 1'b0;
        start_in      = 1'b0;
        #2 rst_in = 1'b0;
        #1 chk_idle({tag, "_async_rst"});
        #2 rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk_idle({tag, "_after_rst"});
        q.delete();
        return;
      end
      if (it.kind != K_EDGE || r) void'(q.pop_front());
      @(posedge clk_in); #1;
      m++;
    end
    chk({tag, "_completed"}, 64'(q.size() == 0), 64'd1);
    start_in      = 1'b0;
    edge_ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_idle({tag, "_post"});
      @(posedge clk_in); #1;
    end
  endtask

  initial begin
    onum = '0;
    for (int i = 0; i < MO; i++) begin
      os[i] = '0;
      for (int j = 0; j < MV; j++) begin
        ox[i][j] = '0;
        oy[i][j] = '0;
      end
    end
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 chk_idle("reset");
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    // Triangle (0,0),(10,0),(0,10), ready held high
    for (int i = 0; i < MO; i++) begin
      os[i] = '0;
      for (int j = 0; j < MV; j++) begin
        ox[i][j] = '0;
        oy[i][j] = '0;
      end
    end
    onum     = 5'd1;
    os[0]    = 4'd3;
    ox[0][1] = 32'sd10;
    oy[0][2] = 32'sd10;
    run("tri", 0, 1'b0, 0);

    // Sides {4,1,2}: obstacle 1 skipped, n=2 gives v0->v1 and v1->v0
    fill_random();
    onum  = 5'd3;
    os[0] = 4'd4;
    os[1] = 4'd1;
    os[2] = 4'd2;
    run("mix", 0, 1'b0, 0);

    // Backpressure with ready 1,0,0,1 on a 4-sided obstacle
    fill_random();
    onum  = 5'd1;
    os[0] = 4'd4;
    run("bp", 2, 1'b0, 0);

    // Empty set, extra start pulses while busy
    fill_random();
    onum = 5'd0;
    run("empty", 0, 1'b1, 0);

    // Clamping: count 20 -> 16, sides 15 -> 8
    fill_random();
    onum = 5'd20;
    for (int i = 0; i < MO; i++) os[i] = 4'd15;
    run("clamp", 1, 1'b0, 0);
    chk("clamp_handshakes", 64'(dut_hs), 64'd128);

    // Random sets with random backpressure and ignored start pulses
    for (int t = 0; t < 4; t++) begin
      fill_random();
      run("rnd", 1, 1'b1, 0);
    end

    // Reset mid-EMIT, then a fresh stream from obstacle 0
    fill_random();
    onum  = 5'd2;
    os[0] = 4'd4;
    run("abort", 0, 1'b0, 3);
    fill_random();
    os[0] = 4'd5;
    run("restart", 1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
